// File: rtl/ps2_mouse_pkg.sv
// Shared constants and state encoding for the PS/2 mouse link controller.
// The helpers describe the fixed power-up handshake as a table over states.
package ps2_mouse_pkg;

   localparam logic [7:0] CMD_RESET     = 8'hFF;
   localparam logic [7:0] CMD_STREAM_EN = 8'hF4;
   localparam logic [7:0] RSP_ACK       = 8'hFA;
   localparam logic [7:0] RSP_BAT_OK    = 8'hAA;
   localparam logic [7:0] RSP_ID_STD    = 8'h00;

   typedef enum logic [3:0] {
      S_SEND_RST    = 4'd0,
      S_WAIT_TX_RST = 4'd1,
      S_WAIT_ACK0   = 4'd2,
      S_WAIT_BAT    = 4'd3,
      S_WAIT_ID     = 4'd4,
      S_SEND_EN     = 4'd5,
      S_WAIT_TX_EN  = 4'd6,
      S_WAIT_ACK1   = 4'd7,
      S_B0          = 4'd8,
      S_B1          = 4'd9,
      S_B2          = 4'd10,
      S_EMIT        = 4'd11
   } ms_state_t;

   // Response byte the device must return in each handshake wait state.
   function automatic logic [7:0] init_rsp(ms_state_t s);
      case (s)
         S_WAIT_BAT: return RSP_BAT_OK;
         S_WAIT_ID:  return RSP_ID_STD;
         default:    return RSP_ACK;
      endcase
   endfunction

   function automatic ms_state_t init_next(ms_state_t s);
      case (s)
         S_WAIT_ACK0: return S_WAIT_BAT;
         S_WAIT_BAT:  return S_WAIT_ID;
         S_WAIT_ID:   return S_SEND_EN;
         default:     return S_B0;
      endcase
   endfunction

   // States that wait on the device and therefore run the timeout timer.
   function automatic logic is_timed(ms_state_t s);
      return s inside {S_WAIT_TX_RST, S_WAIT_ACK0, S_WAIT_BAT, S_WAIT_ID,
                       S_WAIT_TX_EN, S_WAIT_ACK1, S_B1, S_B2};
   endfunction

endpackage

// File: rtl/ps2_mouse_master_ctrl_if.sv
// Byte-level link between the controller, the PS/2 tx/rx pair and the packet consumers.
interface ps2_mouse_master_ctrl_if;
   logic       send_byte;
   logic [7:0] byte_to_send;
   logic       byte_sent;
   logic       byte_ready;
   logic [7:0] byte_read;
   logic [1:0] byte_err;
   logic [7:0] mouse_status;
   logic [7:0] mouse_dx;
   logic [7:0] mouse_dy;
   logic       packet_valid;
   logic       init_done;

   modport master (
      output send_byte, byte_to_send, mouse_status, mouse_dx, mouse_dy, packet_valid, init_done,
      input  byte_sent, byte_ready, byte_read, byte_err
   );

   modport slave (
      input  send_byte, byte_to_send, mouse_status, mouse_dx, mouse_dy, packet_valid, init_done,
      output byte_sent, byte_ready, byte_read, byte_err
   );
endinterface

// File: rtl/ps2_timeout_timer.sv
// Response-wait timer: counts enabled cycles and flags expiry on the last one.
module ps2_timeout_timer #(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int TCNT_W         = 26
) (
   input  logic clk_100M,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TCNT_W-1:0] LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

   logic [TCNT_W-1:0] cnt_q;

   assign expired = enable && (cnt_q == LAST);

   // Holds at LAST until the owner reacts; the owner always clears on expiry.
   always_ff @(posedge clk_100M or posedge reset) begin
      if (reset)                    cnt_q <= '0;
      else if (clear)               cnt_q <= '0;
      else if (enable && !expired)  cnt_q <= cnt_q + TCNT_W'(1);
   end

endmodule

// File: rtl/ps2_mouse_master_ctrl.sv
// PS/2 mouse link sequencer: power-up handshake, stream enable, 3-byte packet assembly.
// Packet outputs are registered so they change only as a complete, validated set.
module ps2_mouse_master_ctrl
   import ps2_mouse_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int TCNT_W         = 26
) (
   input  logic                     clk_100M,
   input  logic                     reset,
   ps2_mouse_master_ctrl_if.master  bus
);

   ms_state_t  state_q, state_d;
   logic       send_d;
   logic [7:0] tx_byte_d;
   logic       ld_b0, ld_b1, ld_b2, emit;
   logic       rx_ok;
   logic       tmr_clr, tmr_en, tmr_exp;
   logic [7:0] pkt_b0, pkt_b1, pkt_b2;

   assign rx_ok   = bus.byte_ready && (bus.byte_err == 2'd0);
   assign tmr_en  = is_timed(state_q);
   assign tmr_clr = (state_d != state_q) || bus.byte_ready;

   ps2_timeout_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TCNT_W         (TCNT_W)
   ) u_tmr (
      .clk_100M (clk_100M),
      .reset    (reset),
      .clear    (tmr_clr),
      .enable   (tmr_en),
      .expired  (tmr_exp)
   );

   always_ff @(posedge clk_100M or posedge reset) begin
      if (reset) state_q <= S_SEND_RST;
      else       state_q <= state_d;
   end

   // A received byte is checked before expiry so a byte arriving on the last cycle wins.
   always_comb begin
      state_d   = state_q;
      send_d    = 1'b0;
      tx_byte_d = 8'h00;
      ld_b0     = 1'b0;
      ld_b1     = 1'b0;
      ld_b2     = 1'b0;
      emit      = 1'b0;
      case (state_q)
         S_SEND_RST: begin
            send_d    = 1'b1;
            tx_byte_d = CMD_RESET;
            state_d   = S_WAIT_TX_RST;
         end
         S_SEND_EN: begin
            send_d    = 1'b1;
            tx_byte_d = CMD_STREAM_EN;
            state_d   = S_WAIT_TX_EN;
         end
         S_WAIT_TX_RST, S_WAIT_TX_EN: begin
            if (bus.byte_sent)
               state_d = (state_q == S_WAIT_TX_RST) ? S_WAIT_ACK0 : S_WAIT_ACK1;
            else if (tmr_exp)
               state_d = S_SEND_RST;
         end
         S_WAIT_ACK0, S_WAIT_BAT, S_WAIT_ID, S_WAIT_ACK1: begin
            if (bus.byte_ready)
               state_d = (rx_ok && bus.byte_read == init_rsp(state_q)) ? init_next(state_q)
                                                                       : S_SEND_RST;
            else if (tmr_exp)
               state_d = S_SEND_RST;
         end
         S_B0: begin
            if (rx_ok && bus.byte_read[3]) begin
               ld_b0   = 1'b1;
               state_d = S_B1;
            end
         end
         S_B1, S_B2: begin
            if (rx_ok) begin
               ld_b1   = (state_q == S_B1);
               ld_b2   = (state_q == S_B2);
               state_d = (state_q == S_B1) ? S_B2 : S_EMIT;
            end else if (bus.byte_ready || tmr_exp) begin
               state_d = S_B0;
            end
         end
         S_EMIT: begin
            emit    = 1'b1;
            state_d = S_B0;
         end
         default: state_d = S_SEND_RST;
      endcase
   end

   always_ff @(posedge clk_100M or posedge reset) begin
      if (reset) begin
         bus.send_byte    <= 1'b0;
         bus.byte_to_send <= 8'h00;
         bus.packet_valid <= 1'b0;
         bus.mouse_status <= 8'h00;
         bus.mouse_dx     <= 8'h00;
         bus.mouse_dy     <= 8'h00;
         pkt_b0           <= 8'h00;
         pkt_b1           <= 8'h00;
         pkt_b2           <= 8'h00;
      end else begin
         bus.send_byte    <= send_d;
         bus.byte_to_send <= tx_byte_d;
         bus.packet_valid <= emit;
         if (ld_b0) pkt_b0 <= bus.byte_read;
         if (ld_b1) pkt_b1 <= bus.byte_read;
         if (ld_b2) pkt_b2 <= bus.byte_read;
         if (emit) begin
            bus.mouse_status <= pkt_b0;
            bus.mouse_dx     <= pkt_b1;
            bus.mouse_dy     <= pkt_b2;
         end
      end
   end

   assign bus.init_done = state_q inside {S_B0, S_B1, S_B2, S_EMIT};

endmodule

// File: tb/tb_ps2_mouse_master_ctrl.sv
// Bench for ps2_mouse_master_ctrl: directed device behaviour, queue-based reference model,
// per-cycle compare of every output plus literal spot checks.
module tb_ps2_mouse_master_ctrl;

   localparam int T = 200;

   typedef struct {
      int         due;
      logic [7:0] s, x, y;
   } pkt_t;

   logic clk_100M = 1'b0;
   logic reset;
   always #5 clk_100M = ~clk_100M;

   ps2_mouse_master_ctrl_if bus();

   ps2_mouse_master_ctrl #(.TIMEOUT_CYCLES(T), .TCNT_W(10)) dut (
      .clk_100M (clk_100M),
      .reset    (reset),
      .bus      (bus)
   );

   int cyc = 0;
   always @(posedge clk_100M) cyc <= cyc + 1;

   int total = 0, bad = 0, pv_cnt = 0;

   // model state: handshake progress (0..6, 6 = streaming), partial packet, scheduled packets
   int         m_step;
   bit         m_stream;
   int         m_init_cyc;
   int         m_last;
   logic [7:0] m_s, m_x, m_y;
   logic [7:0] m_part[$];
   pkt_t       m_due[$];

   bit         snd_flag;
   logic [7:0] snd_val;
   int         snd_cyc;
   int         sent_cyc;
   int         rel_cyc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic m_reset();
      m_step = 0; m_stream = 0; m_init_cyc = 0; m_last = 0;
      m_s = 8'h00; m_x = 8'h00; m_y = 8'h00;
      m_part.delete(); m_due.delete();
      snd_flag = 0;
   endtask

   task automatic m_sent();
      if (m_step == 0 || m_step == 4) m_step++;
   endtask

   task automatic m_rx(input logic [7:0] b, input logic [1:0] err);
      logic [7:0] want;
      pkt_t p;
      if (m_step inside {1, 2, 3, 5}) begin
         want = (m_step == 2) ? 8'hAA : (m_step == 3) ? 8'h00 : 8'hFA;
         if (err == 2'd0 && b == want) begin
            m_step++;
            if (m_step == 6) begin m_stream = 1; m_init_cyc = cyc + 1; end
         end else begin
            m_step = 0;
         end
      end else if (m_step == 6) begin
         if (m_part.size() > 0 && cyc - m_last > T) m_part.delete();
         m_last = cyc;
         if (err != 2'd0) m_part.delete();
         else if (m_part.size() > 0 || b[3]) begin
            m_part.push_back(b);
            if (m_part.size() == 3) begin
               p.due = cyc + 2; p.s = m_part[0]; p.x = m_part[1]; p.y = m_part[2];
               m_due.push_back(p);
               m_part.delete();
            end
         end
      end
   endtask

   // per-cycle compare against the model
   always @(negedge clk_100M) begin
      logic exp_pv;
      if (reset) begin
         chk("rst_send_byte", bus.send_byte, 0);
         chk("rst_packet_valid", bus.packet_valid, 0);
         chk("rst_init_done", bus.init_done, 0);
         chk("rst_status", bus.mouse_status, 0);
      end else begin
         exp_pv = 1'b0;
         if (m_due.size() > 0 && m_due[0].due == cyc) begin
            exp_pv = 1'b1;
            m_s = m_due[0].s; m_x = m_due[0].x; m_y = m_due[0].y;
            void'(m_due.pop_front());
         end
         chk("packet_valid", bus.packet_valid, exp_pv);
         if (bus.packet_valid) pv_cnt++;
         chk("mouse_status", bus.mouse_status, m_s);
         chk("mouse_dx", bus.mouse_dx, m_x);
         chk("mouse_dy", bus.mouse_dy, m_y);
         chk("init_done", bus.init_done, (m_stream && cyc >= m_init_cyc));
         if (bus.send_byte) begin
            snd_flag = 1; snd_val = bus.byte_to_send; snd_cyc = cyc;
            if (m_step == 0)      chk("cmd_byte", bus.byte_to_send, 8'hFF);
            else if (m_step == 4) chk("cmd_byte", bus.byte_to_send, 8'hF4);
            else                  chk("send_unexpected_step", m_step, 0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_100M);
      #1;
   endtask

   task automatic wait_send(input logic [7:0] exp, input int bound, input string nm);
      int n = 0;
      while (!snd_flag && n < bound) begin tick(1); n++; end
      if (!snd_flag) begin
         total++; bad++;
         $display("FAIL %s: no send_byte within %0d cycles, expected %0h", nm, bound, exp);
      end else begin
         snd_flag = 0;
         chk(nm, snd_val, exp);
         tick(1);
      end
   endtask

   task automatic sent();
      bus.byte_sent = 1'b1; sent_cyc = cyc; m_sent();
      tick(1);
      bus.byte_sent = 1'b0;
   endtask

   task automatic rx(input logic [7:0] b, input logic [1:0] err);
      bus.byte_ready = 1'b1; bus.byte_read = b; bus.byte_err = err;
      m_rx(b, err);
      tick(1);
      bus.byte_ready = 1'b0; bus.byte_err = 2'd0;
      tick(2);
   endtask

   task automatic do_init(input bit have_ff);
      if (!have_ff) wait_send(8'hFF, 20, "init_cmd_reset");
      sent();
      rx(8'hFA, 2'd0);
      rx(8'hAA, 2'd0);
      rx(8'h00, 2'd0);
      wait_send(8'hF4, 20, "init_cmd_enable");
      sent();
      rx(8'hFA, 2'd0);
      chk("init_done_after_ack", bus.init_done, 1);
   endtask

   task automatic do_reset();
      bus.byte_ready = 1'b0; bus.byte_sent = 1'b0; bus.byte_err = 2'd0;
      reset = 1'b1; m_reset();
      tick(3);
      reset = 1'b0; rel_cyc = cyc;
   endtask

   initial begin
      bus.byte_sent = 1'b0; bus.byte_ready = 1'b0; bus.byte_read = 8'h00; bus.byte_err = 2'd0;
      reset = 1'b1; m_reset();
      tick(3);
      // reset state
      chk("reset_send_byte", bus.send_byte, 0);
      chk("reset_byte_to_send", bus.byte_to_send, 0);
      chk("reset_packet_valid", bus.packet_valid, 0);
      chk("reset_init_done", bus.init_done, 0);
      chk("reset_dx", bus.mouse_dx, 0);
      chk("reset_dy", bus.mouse_dy, 0);
      reset = 1'b0;

      // 1: clean handshake
      do_init(0);

      // 2: one packet
      rx(8'h08, 2'd0); rx(8'h05, 2'd0); rx(8'hFB, 2'd0);
      tick(3);
      chk("p1_status", bus.mouse_status, 8'h08);
      chk("p1_dx", bus.mouse_dx, 8'h05);
      chk("p1_dy", bus.mouse_dy, 8'hFB);
      chk("p1_count", pv_cnt, 1);
      chk("p1_init_done", bus.init_done, 1);

      // 3: resync on bit3=0
      rx(8'h00, 2'd0); rx(8'h09, 2'd0); rx(8'h01, 2'd0); rx(8'h02, 2'd0);
      tick(3);
      chk("p2_status", bus.mouse_status, 8'h09);
      chk("p2_dx", bus.mouse_dx, 8'h01);
      chk("p2_dy", bus.mouse_dy, 8'h02);
      chk("p2_count", pv_cnt, 2);

      // 4a: wrong BAT byte restarts the handshake
      do_reset();
      wait_send(8'hFF, 20, "4a_cmd_reset");
      sent();
      rx(8'hFA, 2'd0);
      rx(8'hFC, 2'd0);
      chk("4a_init_done", bus.init_done, 0);
      do_init(0);

      // 4b: withheld ACK times out and re-sends FF
      do_reset();
      wait_send(8'hFF, 20, "4b_cmd_reset");
      sent();
      m_step = 0;  // device stays silent; controller must give up on its own
      wait_send(8'hFF, T + 50, "4b_cmd_reset_after_timeout");
      chk("4b_timeout_latency", snd_cyc - sent_cyc, T + 2);
      do_init(1);

      // 5: mid-packet stall drops the partial packet
      pv_cnt = 0;
      rx(8'h08, 2'd0); rx(8'h05, 2'd0);
      tick(T + 20);
      chk("5_no_packet", pv_cnt, 0);
      chk("5_init_done", bus.init_done, 1);
      rx(8'h0A, 2'd0); rx(8'h01, 2'd0); rx(8'h01, 2'd0);
      tick(3);
      chk("5_status", bus.mouse_status, 8'h0A);
      chk("5_dx", bus.mouse_dx, 8'h01);
      chk("5_dy", bus.mouse_dy, 8'h01);
      chk("5_count", pv_cnt, 1);

      // 6: reset mid-packet, then byte_err on the BAT byte
      rx(8'h08, 2'd0);
      reset = 1'b1; m_reset();
      #1;
      chk("6_rst_status", bus.mouse_status, 0);
      chk("6_rst_dx", bus.mouse_dx, 0);
      chk("6_rst_init_done", bus.init_done, 0);
      tick(2);
      reset = 1'b0; rel_cyc = cyc;
      wait_send(8'hFF, 5, "6_cmd_reset");
      chk("6_send_within_2", (snd_cyc - rel_cyc) <= 2, 1);
      sent();
      rx(8'hFA, 2'd0);
      rx(8'hAA, 2'd1);
      chk("6_err_init_done", bus.init_done, 0);
      do_init(0);

      // error inside a packet discards it; next packet is clean
      pv_cnt = 0;
      rx(8'h08, 2'd0); rx(8'h05, 2'd2);
      rx(8'h0C, 2'd0); rx(8'h01, 2'd0); rx(8'h02, 2'd0);
      tick(3);
      chk("7_status", bus.mouse_status, 8'h0C);
      chk("7_dy", bus.mouse_dy, 8'h02);
      chk("7_count", pv_cnt, 1);

      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
